// File: rtl/ring_nic_q.sv
// Ring network interface: a CPU-facing register port bridging two small FIFOs.
// The input queue (IQ) carries router-to-CPU packets; the output queue (OQ) carries CPU-to-router packets.
module ring_nic_q #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] d_in,
  input  logic             nicEn,
  input  logic             nicWrEn,
  output logic [WIDTH-1:0] d_out,
  input  logic             net_polarity,
  input  logic             net_ro,
  output logic             net_so,
  output logic [WIDTH-1:0] net_do,
  input  logic             net_si,
  output logic             net_ri,
  input  logic [WIDTH-1:0] net_di
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] iq_mem [DEPTH];
  logic [WIDTH-1:0] oq_mem [DEPTH];
  logic [PW-1:0]    iq_rd, iq_wr, oq_rd, oq_wr;
  logic [CW-1:0]    iq_cnt, oq_cnt;
  logic             ovf;

  logic iq_full, iq_empty, oq_full, oq_empty;
  logic cpu_rd, cpu_wr;
  logic iq_push, iq_pop, oq_push, oq_pop, ovf_set, ovf_clr;

  assign iq_full  = (iq_cnt == CW'(DEPTH));
  assign iq_empty = (iq_cnt == '0);
  assign oq_full  = (oq_cnt == CW'(DEPTH));
  assign oq_empty = (oq_cnt == '0);

  assign cpu_rd = nicEn && !nicWrEn;
  assign cpu_wr = nicEn && nicWrEn;

  // Accept decisions use only pre-edge counts, so net_ri never depends on net_si.
  assign net_ri  = !reset && !iq_full;
  assign iq_push = net_si && net_ri;
  assign iq_pop  = cpu_rd && (addr == 2'b00) && !iq_empty;

  assign net_do  = oq_mem[oq_rd];
  assign net_so  = !reset && !oq_empty && net_ro && (net_do[WIDTH-1] == net_polarity);
  assign oq_pop  = net_so;
  assign oq_push = cpu_wr && (addr == 2'b10) && !oq_full;
  assign ovf_set = cpu_wr && (addr == 2'b10) && oq_full;
  assign ovf_clr = cpu_rd && (addr == 2'b11);

  always_comb begin
    d_out = '0;
    if (!reset && cpu_rd) begin
      case (addr)
        2'b00: if (!iq_empty) d_out = iq_mem[iq_rd];
        2'b01: d_out[1:0] = {ovf, !iq_empty};
        2'b11: d_out[0] = oq_full;
        default: d_out = '0;
      endcase
    end
  end

  // Packet storage is not reset; only pointers, counts and the flag are.
  always_ff @(posedge clk) begin
    if (iq_push) iq_mem[iq_wr] <= net_di;
    if (oq_push) oq_mem[oq_wr] <= d_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iq_rd  <= '0;
      iq_wr  <= '0;
      iq_cnt <= '0;
      oq_rd  <= '0;
      oq_wr  <= '0;
      oq_cnt <= '0;
      ovf    <= 1'b0;
    end else begin
      if (iq_push) iq_wr <= iq_wr + 1'b1;
      if (iq_pop)  iq_rd <= iq_rd + 1'b1;
      if (iq_push && !iq_pop)      iq_cnt <= iq_cnt + 1'b1;
      else if (!iq_push && iq_pop) iq_cnt <= iq_cnt - 1'b1;

      if (oq_push) oq_wr <= oq_wr + 1'b1;
      if (oq_pop)  oq_rd <= oq_rd + 1'b1;
      if (oq_push && !oq_pop)      oq_cnt <= oq_cnt + 1'b1;
      else if (!oq_push && oq_pop) oq_cnt <= oq_cnt - 1'b1;

      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_nic_q.sv
// Bench for ring_nic_q: directed scenarios plus random traffic against a queue-based reference model.
module tb_ring_nic_q;

  localparam int W = 64;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   addr;
  logic [W-1:0] d_in;
  logic         nicEn, nicWrEn;
  logic [W-1:0] d_out;
  logic         net_polarity, net_ro, net_so, net_si, net_ri;
  logic [W-1:0] net_do, net_di;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] iq_q[$];
  logic [W-1:0] oq_q[$];
  logic         m_ovf;

  logic [W-1:0] o_dout, o_do;
  logic         o_ri, o_so;

  ring_nic_q #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .nicEn(nicEn),
    .nicWrEn(nicWrEn), .d_out(d_out), .net_polarity(net_polarity),
    .net_ro(net_ro), .net_so(net_so), .net_do(net_do), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model and DUT.
  task automatic cycle(input logic en, input logic wr, input logic [1:0] a,
                       input logic [W-1:0] d, input logic si, input logic [W-1:0] di,
                       input logic ro, input logic pol);
    logic [W-1:0] exp_dout;
    logic exp_ri, exp_so, rd;
    nicEn = en; nicWrEn = wr; addr = a; d_in = d;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
    #1;
    rd       = en && !wr;
    exp_ri   = (iq_q.size() < D);
    exp_so   = (oq_q.size() > 0) && ro && (oq_q[0][W-1] == pol);
    exp_dout = '0;
    if (rd) begin
      case (a)
        2'b00: if (iq_q.size() > 0) exp_dout = iq_q[0];
        2'b01: begin exp_dout[1] = m_ovf; exp_dout[0] = (iq_q.size() > 0); end
        2'b11: exp_dout[0] = (oq_q.size() == D);
        default: exp_dout = '0;
      endcase
    end
    o_dout = d_out; o_ri = net_ri; o_so = net_so; o_do = net_do;
    check("net_ri", {63'd0, net_ri}, {63'd0, exp_ri});
    check("net_so", {63'd0, net_so}, {63'd0, exp_so});
    check("d_out", d_out, exp_dout);
    if (exp_so) check("net_do", net_do, oq_q[0]);
    if (rd && a == 2'b00 && iq_q.size() > 0) void'(iq_q.pop_front());
    if (exp_so) void'(oq_q.pop_front());
    if (si && exp_ri) iq_q.push_back(di);
    if (en && wr && a == 2'b10) begin
      if (oq_q.size() < D) oq_q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (rd && a == 2'b11) m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ro, input logic pol);
    cycle(1'b0, 1'b0, 2'b00, '0, 1'b0, '0, ro, pol);
  endtask

  // Reset held across two edges with traffic present; outputs must be forced low.
  task automatic do_reset(input logic si);
    reset = 1'b1;
    nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b01; net_si = si; net_ro = 1'b1;
    net_polarity = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_net_ri", {63'd0, net_ri}, '0);
      check("rst_net_so", {63'd0, net_so}, '0);
      check("rst_d_out", d_out, '0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    iq_q.delete(); oq_q.delete(); m_ovf = 1'b0;
  endtask

  logic [W-1:0] big;

  initial begin
    reset = 1'b1; addr = '0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_polarity = 1'b0; net_ro = 1'b0; net_si = 1'b0; net_di = '0;
    m_ovf = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b0);

    // Post-reset status
    cycle(1'b1, 1'b0, 2'b01, '0, 1'b0, '0, 1'b0, 1'b0);
    check("init_status", o_dout, '0);
    check("init_ri", {63'd0, o_ri}, 64'd1);
    check("init_so", {63'd0, o_so}, 64'd0);

    // Router fills IQ, third packet is dropped
    cycle(1'b0, 1'b0, 2'b00, '0, 1'b1, 64'h1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, '0, 1'b1, 64'h2, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, '0, 1'b1, 64'h3, 1'b0, 1'b0);
    check("iq_full_ri", {63'd0, o_ri}, 64'd0);
    cycle(1'b1, 1'b0, 2'b00, '0, 1'b0, '0, 1'b0, 1'b0);
    check("iq_rd1", o_dout, 64'h1);
    cycle(1'b1, 1'b0, 2'b00, '0, 1'b0, '0, 1'b0, 1'b0);
    check("iq_rd2", o_dout, 64'h2);
    cycle(1'b1, 1'b0, 2'b00, '0, 1'b0, '0, 1'b0, 1'b0);
    check("iq_rd_empty", o_dout, 64'h0);
    cycle(1'b1, 1'b0, 2'b01, '0, 1'b0, '0, 1'b0, 1'b0);
    check("iq_status_empty", o_dout, 64'h0);

    // Polarity gating on send
    big = 64'h8000_0000_0000_00AA;
    cycle(1'b1, 1'b1, 2'b10, big, 1'b0, '0, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check("pol_mismatch_so", {63'd0, o_so}, 64'd0);
    idle(1'b1, 1'b1);
    check("pol_match_so", {63'd0, o_so}, 64'd1);
    check("pol_match_do", o_do, big);
    idle(1'b1, 1'b1);
    check("sent_once_so", {63'd0, o_so}, 64'd0);

    // OQ overflow and sticky flag
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 2'b10, 64'(i + 16), 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2'b01, '0, 1'b0, '0, 1'b0, 1'b0);
    check("ovf_set", o_dout, 64'h2);
    cycle(1'b1, 1'b0, 2'b11, '0, 1'b0, '0, 1'b0, 1'b0);
    check("oq_full", o_dout, 64'h1);
    cycle(1'b1, 1'b0, 2'b01, '0, 1'b0, '0, 1'b0, 1'b0);
    check("ovf_cleared", o_dout, 64'h0);
    idle(1'b1, 1'b0);
    check("drain_a", o_do, 64'd16);
    idle(1'b1, 1'b0);
    check("drain_b", o_do, 64'd17);

    // Simultaneous write and send across pointer wrap
    cycle(1'b1, 1'b1, 2'b10, 64'h100, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 2'b10, 64'(12'h101 + i), 1'b0, '0, 1'b1, 1'b0);
      check("wrap_order", o_do, 64'(12'h100 + i));
    end
    cycle(1'b1, 1'b0, 2'b11, '0, 1'b0, '0, 1'b0, 1'b0);
    check("wrap_not_full", o_dout, 64'h0);
    idle(1'b1, 1'b0);
    check("wrap_last", o_do, 64'h108);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] rd_d, rd_di;
      rd_d  = {$urandom, $urandom};
      rd_di = {$urandom, $urandom};
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
            rd_d, 1'($urandom), rd_di, 1'($urandom_range(0, 3) != 0), 1'($urandom));
    end

    // Reset while IQ full and router still sending
    cycle(1'b0, 1'b0, 2'b00, '0, 1'b1, 64'h55, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, '0, 1'b1, 64'h66, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, '0, 1'b1, 64'h77, 1'b0, 1'b0);
    do_reset(1'b1);
    cycle(1'b1, 1'b0, 2'b01, '0, 1'b0, '0, 1'b1, 1'b0);
    check("post_rst_ri", {63'd0, o_ri}, 64'd1);
    check("post_rst_so", {63'd0, o_so}, 64'd0);
    check("post_rst_status", o_dout, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_nic_q.md
RING_NIC_Q -- requirements
Module: ring_nic_q

Interface
REQ-001 SHALL have parameter WIDTH, default 64: packet width in bits.
REQ-002 SHALL have parameter DEPTH, default 2: entries per queue; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port addr, input, 2: CPU register select.
REQ-006 SHALL have port d_in, input, WIDTH: CPU write data.
REQ-007 SHALL have port nicEn, input, 1: CPU access enable.
REQ-008 SHALL have port nicWrEn, input, 1: CPU write when 1, read when 0; qualified by nicEn.
REQ-009 SHALL have port d_out, output, WIDTH: CPU read data, combinational from addr and current state.
REQ-010 SHALL have port net_polarity, input, 1: ring virtual-channel phase.
REQ-011 SHALL have port net_ro, input, 1: router ready to accept a packet from this block.
REQ-012 SHALL have port net_so, output, 1: packet valid toward the router.
REQ-013 SHALL have port net_do, output, WIDTH: packet toward the router; equals the output-queue head.
REQ-014 SHALL have port net_si, input, 1: packet valid from the router.
REQ-015 SHALL have port net_ri, output, 1: this block ready to accept a packet from the router.
REQ-016 SHALL have port net_di, input, WIDTH: packet from the router.

Function
REQ-017 SHALL contain two DEPTH-entry FIFOs: input queue (IQ, router to CPU) and output queue (OQ, CPU to router).
REQ-018 Each FIFO SHALL have a read pointer and a write pointer of log2(DEPTH) bits that wrap modulo DEPTH, plus a count from 0 to DEPTH.
REQ-019 Address map SHALL be:
- 00: read returns the IQ head.
- 01: read returns IQ status.
- 10: write pushes to the OQ.
- 11: read returns OQ status.
REQ-020 A CPU read of 00 with IQ non-empty SHALL return the head and pop IQ at the edge; with IQ empty it SHALL return 0 and leave IQ unchanged.
REQ-021 IQ status read SHALL return:
- d_out[0] = IQ non-empty.
- d_out[1] = sticky OQ-overflow flag.
- all other bits 0.
REQ-022 OQ status read SHALL return d_out[0] = OQ full, all other bits 0; a read of 11 SHALL clear the overflow flag at the edge.
REQ-023 A CPU write to 10 SHALL push d_in when the pre-edge OQ count is below DEPTH; otherwise the data is dropped and the overflow flag set.
REQ-024 Writes to 00, 01 or 11 SHALL be ignored; reads of 10 SHALL return 0; with nicEn=0, d_out SHALL be 0 and there is no side effect.
REQ-025 net_ri SHALL equal (IQ count < DEPTH); an IQ push SHALL occur exactly when net_si and net_ri are both 1.
REQ-026 net_si while net_ri=0 SHALL be ignored and IQ contents left unchanged.
REQ-027 net_so SHALL equal OQ non-empty AND net_ro AND (OQ head bit WIDTH-1 == net_polarity); an OQ pop SHALL occur on every edge where net_so=1.
REQ-028 Simultaneous push and pop on the same FIFO in one cycle SHALL both take effect, with the count unchanged; pointer wrap SHALL preserve FIFO order.
REQ-029 Fullness for accept decisions SHALL use the pre-edge count; a pop in the same cycle SHALL NOT make a full queue accept.
REQ-030 No combinational path SHALL exist from net_si to net_ri, nor from net_so to any CPU-side input.

Reset
REQ-031 While reset=1, the block SHALL clear pointers and counts to 0, clear the overflow flag, and force net_so=0, net_ri=0 and d_out=0.
REQ-032 Reset asserted mid-transfer SHALL discard all queued packets; the first edge after deassertion SHALL see net_ri=1, net_so=0 and both queues empty.
REQ-033 FIFO data storage need not be reset.

Verification
REQ-034 Reset, then IQ-status read -> d_out=0; net_ri=1; net_so=0.
REQ-035 Router sends 0x1 then 0x2 (net_si=1, 2 cycles), then a third packet -> net_ri=0 after the second; third packet dropped; CPU reads of 00 return 0x1, 0x2, then 0 with status 0.
REQ-036 CPU writes 0x8000_0000_0000_00AA to 10 with net_ro=1 and net_polarity=0 -> net_so stays 0; net_polarity=1 -> net_so=1 for one cycle with net_do equal to that value.
REQ-037 Three OQ writes with net_ro=0 -> OQ status reads 1; IQ status bit 1 reads 1; after one read of 11, bit 1 reads 0.
REQ-038 With OQ holding one entry, a same-cycle CPU write and send -> count stays 1 and order is preserved across pointer wrap over 8 packets.
REQ-039 Reset pulsed while IQ is full and net_si=1 -> net_ri=0 during reset, then 1; IQ-status read returns 0.
